// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared constants for the pipeline hazard controller.
//
// The block of `defines at the top is the shared define header. It holds
// the project-wide `XLEN_WIDTH / `TRUE / `FALSE constants together with the
// hazard-controller state encodings, pause-kind codes and the default wait
// limit. The package mirrors these as typed localparams so that RTL can
// import them instead of using raw macros.
//
// Contents:
//   ST_RUN / ST_WAIT_JUMP / ST_WAIT_LOAD  FSM state encodings
//   KIND_JUMP / KIND_LOAD                 id_pause_kind codes
//   MAX_WAIT_DEFAULT                      default wait-state timeout limit
//   ctrl_t                                bundle of the pipeline control strobes
//   waitWidth()                           width of a counter that counts 0..maxWait-1

`ifndef PIPE_CTRL_DEFS_SVH
`define PIPE_CTRL_DEFS_SVH

`ifndef XLEN_WIDTH
`define XLEN_WIDTH 32
`endif

`ifndef TRUE
`define TRUE 1'b1
`endif

`ifndef FALSE
`define FALSE 1'b0
`endif

`define PC_ST_RUN           2'd0
`define PC_ST_WAIT_JUMP     2'd1
`define PC_ST_WAIT_LOAD     2'd2
`define PC_KIND_JUMP        1'b0
`define PC_KIND_LOAD        1'b1
`define PC_MAX_WAIT_DEFAULT 15

`endif

package pipe_ctrl_pkg;

  localparam logic [1:0] ST_RUN       = `PC_ST_RUN;
  localparam logic [1:0] ST_WAIT_JUMP = `PC_ST_WAIT_JUMP;
  localparam logic [1:0] ST_WAIT_LOAD = `PC_ST_WAIT_LOAD;

  localparam logic KIND_JUMP = `PC_KIND_JUMP;
  localparam logic KIND_LOAD = `PC_KIND_LOAD;

  localparam int MAX_WAIT_DEFAULT = `PC_MAX_WAIT_DEFAULT;

  // All pipeline control strobes driven by the controller in one cycle.
  typedef struct packed {
    logic pcHold;
    logic pcLoad;
    logic ifIdHold;
    logic ifIdFlush;
    logic idExFlush;
  } ctrl_t;

  // The wait counter only ever needs to reach maxWait-1, so clog2(maxWait)
  // bits suffice; tiny limits still get one bit.
  function automatic int waitWidth(input int maxWait);
    return (maxWait > 2) ? $clog2(maxWait) : 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up-counter that sticks at all-ones instead of wrapping.
//
// Ports:
//   clk    clock, counts on the rising edge
//   rst    asynchronous active-high reset, clears the count
//   inc    add one this cycle (ignored once saturated)
//   clr    synchronous clear, wins over inc
//   value  current count

module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise increment unless already all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller for the PC / IF->ID / ID->EX stages.
//
// Decode pauses the front end for an unresolved jump (WAIT_JUMP) or for an
// outstanding load (WAIT_LOAD). A taken redirect from EX always wins and
// reloads the PC. A wait that lasts MAX_WAIT cycles is aborted, and the
// sticky timeout_err flag is set.
//
// Ports:
//   clk, rst                 clock / asynchronous active-high reset
//   id_pause, id_pause_kind  decode pause request and its kind (0 jump, 1 load)
//   ex_resolve, ex_taken     EX resolved a control transfer / it redirects
//   ex_target                redirect address
//   mem_load_done            load data returned this cycle
//   pc_hold, pc_load         freeze PC / load PC with pc_target
//   pc_target                redirect address, 0 unless pc_load
//   if_id_hold, if_id_flush  freeze / bubble the IF->ID register
//   id_ex_flush              bubble the ID->EX register
//   timeout_err              sticky wait-timeout flag
//   stall_cycles             saturating count of cycles with pc_hold or pc_load

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_pause,
  input  logic                   id_pause_kind,
  input  logic                   ex_resolve,
  input  logic                   ex_taken,
  input  logic [`XLEN_WIDTH-1:0] ex_target,
  input  logic                   mem_load_done,
  output logic                   pc_hold,
  output logic                   pc_load,
  output logic [`XLEN_WIDTH-1:0] pc_target,
  output logic                   if_id_hold,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   timeout_err,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam int                WAIT_W    = waitWidth(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [WAIT_W-1:0]      waitCnt_q;
  logic [WAIT_W-1:0]      waitCnt_d;
  logic                   timeoutErr_q;
  logic                   timeoutErr_d;
  ctrl_t                  ctrl;
  logic [`XLEN_WIDTH-1:0] pcTarget;
  logic                   waitExpired;

  assign waitExpired = (waitCnt_q == WAIT_LAST);

  // Control decode. A taken redirect is checked first so it overrides any
  // pause or load release in the same cycle. A timeout abort drops pc_hold
  // and flushes both stage registers so the front end refetches cleanly.
  always_comb begin
    ctrl         = '0;
    pcTarget     = '0;
    state_d      = state_q;
    timeoutErr_d = timeoutErr_q;
    if (ex_resolve && ex_taken) begin
      ctrl.pcLoad    = 1'b1;
      ctrl.ifIdFlush = 1'b1;
      ctrl.idExFlush = 1'b1;
      pcTarget       = ex_target;
      state_d        = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (id_pause) begin
            ctrl.pcHold = 1'b1;
            if (id_pause_kind == KIND_JUMP) begin
              ctrl.ifIdFlush = 1'b1;
              state_d        = ST_WAIT_JUMP;
            end else begin
              ctrl.ifIdHold = 1'b1;
              state_d       = ST_WAIT_LOAD;
            end
          end
        end
        ST_WAIT_JUMP: begin
          if (ex_resolve) begin
            state_d = ST_RUN;
          end else if (waitExpired) begin
            ctrl.ifIdFlush = 1'b1;
            ctrl.idExFlush = 1'b1;
            timeoutErr_d   = 1'b1;
            state_d        = ST_RUN;
          end else begin
            ctrl.pcHold    = 1'b1;
            ctrl.ifIdFlush = 1'b1;
          end
        end
        ST_WAIT_LOAD: begin
          if (mem_load_done) begin
            state_d = ST_RUN;
          end else if (waitExpired) begin
            ctrl.ifIdFlush = 1'b1;
            ctrl.idExFlush = 1'b1;
            timeoutErr_d   = 1'b1;
            state_d        = ST_RUN;
          end else begin
            ctrl.pcHold    = 1'b1;
            ctrl.ifIdHold  = 1'b1;
            ctrl.idExFlush = 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // The wait counter only advances while we stay in a wait state. Entering a
  // wait from RUN, leaving a wait, and idling in RUN all clear it.
  always_comb begin
    waitCnt_d = '0;
    if ((state_q != ST_RUN) && (state_d == state_q)) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      waitCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.pcHold | ctrl.pcLoad),
    .clr   (1'b0),
    .value (stall_cycles)
  );

  assign pc_hold     = ctrl.pcHold;
  assign pc_load     = ctrl.pcLoad;
  assign pc_target   = pcTarget;
  assign if_id_hold  = ctrl.ifIdHold;
  assign if_id_flush = ctrl.ifIdFlush;
  assign id_ex_flush = ctrl.idExFlush;
  assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed testbench for pipe_ctrl.
//
// Two instances share every input: dut uses the default 32-bit stall
// counter, and dut4 uses a 4-bit one so that saturation can be observed.
// The control strobes are packed as {pc_hold, pc_load, if_id_hold,
// if_id_flush, id_ex_flush}.

module tb_pipe_ctrl;

  localparam logic       K_JUMP  = 1'b0;
  localparam logic       K_LOAD  = 1'b1;
  localparam logic [4:0] C_IDLE   = 5'b00000;
  localparam logic [4:0] C_JUMP   = 5'b10010;
  localparam logic [4:0] C_LDENT  = 5'b10100;
  localparam logic [4:0] C_LDWAIT = 5'b10101;
  localparam logic [4:0] C_REDIR  = 5'b01011;
  localparam logic [4:0] C_ABORT  = 5'b00011;

  logic                   clk;
  logic                   rst;
  logic                   id_pause;
  logic                   id_pause_kind;
  logic                   ex_resolve;
  logic                   ex_taken;
  logic [`XLEN_WIDTH-1:0] ex_target;
  logic                   mem_load_done;

  logic                   pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_flush, timeout_err;
  logic [`XLEN_WIDTH-1:0] pc_target;
  logic [31:0]            stall_cycles;

  logic                   pc_hold4, pc_load4, if_id_hold4, if_id_flush4, id_ex_flush4, timeout_err4;
  logic [`XLEN_WIDTH-1:0] pc_target4;
  logic [3:0]             stall_cycles4;

  logic [4:0] ctl;
  logic [4:0] ctl4;

  int vectors     = 0;
  int miscompares = 0;

  assign ctl  = {pc_hold, pc_load, if_id_hold, if_id_flush, id_ex_flush};
  assign ctl4 = {pc_hold4, pc_load4, if_id_hold4, if_id_flush4, id_ex_flush4};

  pipe_ctrl #(.MAX_WAIT(15), .CNT_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_pause      (id_pause),
    .id_pause_kind (id_pause_kind),
    .ex_resolve    (ex_resolve),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .mem_load_done (mem_load_done),
    .pc_hold       (pc_hold),
    .pc_load       (pc_load),
    .pc_target     (pc_target),
    .if_id_hold    (if_id_hold),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .timeout_err   (timeout_err),
    .stall_cycles  (stall_cycles)
  );

  pipe_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut4 (
    .clk           (clk),
    .rst           (rst),
    .id_pause      (id_pause),
    .id_pause_kind (id_pause_kind),
    .ex_resolve    (ex_resolve),
    .ex_taken      (ex_taken),
    .ex_target     (ex_target),
    .mem_load_done (mem_load_done),
    .pc_hold       (pc_hold4),
    .pc_load       (pc_load4),
    .pc_target     (pc_target4),
    .if_id_hold    (if_id_hold4),
    .if_id_flush   (if_id_flush4),
    .id_ex_flush   (id_ex_flush4),
    .timeout_err   (timeout_err4),
    .stall_cycles  (stall_cycles4)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change just after the falling edge. Outputs are sampled 1ns
  // later, well clear of the next rising edge.
  task automatic applyStimulus(input logic pause, input logic kind, input logic resolve,
                               input logic taken, input logic loadDone, input logic [31:0] target);
    @(negedge clk);
    id_pause      = pause;
    id_pause_kind = kind;
    ex_resolve    = resolve;
    ex_taken      = taken;
    mem_load_done = loadDone;
    ex_target     = target;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Combinational strobes, redirect target and sticky flag on both instances.
  task automatic checkCtl(input string tag, input logic [4:0] expCtl, input logic [31:0] expTarget,
                          input logic expTimeout);
    checkOutput({tag, ".ctl"},  64'(ctl),          64'(expCtl));
    checkOutput({tag, ".tgt"},  64'(pc_target),    64'(expTarget));
    checkOutput({tag, ".to"},   64'(timeout_err),  64'(expTimeout));
    checkOutput({tag, ".ctl4"}, 64'(ctl4),         64'(expCtl));
    checkOutput({tag, ".tgt4"}, 64'(pc_target4),   64'(expTarget));
    checkOutput({tag, ".to4"},  64'(timeout_err4), 64'(expTimeout));
  endtask

  task automatic checkStall(input string tag, input int expMain, input int expSmall);
    checkOutput({tag, ".stall"},  64'(stall_cycles),  64'(expMain));
    checkOutput({tag, ".stall4"}, 64'(stall_cycles4), 64'(expSmall));
  endtask

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    id_pause      = 1'b0;
    id_pause_kind = 1'b0;
    ex_resolve    = 1'b0;
    ex_taken      = 1'b0;
    ex_target     = '0;
    mem_load_done = 1'b0;
    #7;
    checkCtl("reset", C_IDLE, 32'h0, 1'b0);
    checkStall("reset", 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Jump pause resolved taken two cycles later.
    applyStimulus(1'b1, K_JUMP, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("j.pause", C_JUMP, 32'h0, 1'b0);
    applyStimulus(1'b0, K_JUMP, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("j.wait", C_JUMP, 32'h0, 1'b0);
    applyStimulus(1'b0, K_JUMP, 1'b1, 1'b1, 1'b0, 32'h0000_0100);
    checkCtl("j.redir", C_REDIR, 32'h0000_0100, 1'b0);
    applyStimulus(1'b0, K_JUMP, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("j.run", C_IDLE, 32'h0, 1'b0);
    checkStall("j", 3, 3);

    // A not-taken resolve in RUN does nothing, and the target is not leaked.
    applyStimulus(1'b0, K_JUMP, 1'b1, 1'b0, 1'b0, 32'h0000_0300);
    checkCtl("run.nt", C_IDLE, 32'h0, 1'b0);

    // Load pause released four cycles later. A not-taken resolve mid-wait
    // has no effect.
    applyStimulus(1'b1, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("l.pause", C_LDENT, 32'h0, 1'b0);
    applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("l.w1", C_LDWAIT, 32'h0, 1'b0);
    applyStimulus(1'b0, K_LOAD, 1'b1, 1'b0, 1'b0, 32'h0000_0300);
    checkCtl("l.w2nt", C_LDWAIT, 32'h0, 1'b0);
    applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("l.w3", C_LDWAIT, 32'h0, 1'b0);
    applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b1, 32'h0);
    checkCtl("l.done", C_IDLE, 32'h0, 1'b0);
    applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("l.run", C_IDLE, 32'h0, 1'b0);
    checkStall("l", 7, 7);

    // Jump wait released by a not-taken resolve, then a redirect that
    // beats a fresh pause request.
    applyStimulus(1'b1, K_JUMP, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("jn.pause", C_JUMP, 32'h0, 1'b0);
    applyStimulus(1'b0, K_JUMP, 1'b1, 1'b0, 1'b0, 32'h0000_0500);
    checkCtl("jn.nt", C_IDLE, 32'h0, 1'b0);
    applyStimulus(1'b1, K_JUMP, 1'b1, 1'b1, 1'b0, 32'h0000_0040);
    checkCtl("pr.redir", C_REDIR, 32'h0000_0040, 1'b0);
    applyStimulus(1'b0, K_JUMP, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("pr.run", C_IDLE, 32'h0, 1'b0);
    checkStall("pr", 9, 9);

    // Load release and taken redirect arrive together; the redirect wins.
    applyStimulus(1'b1, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("lr.pause", C_LDENT, 32'h0, 1'b0);
    applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("lr.wait", C_LDWAIT, 32'h0, 1'b0);
    applyStimulus(1'b0, K_LOAD, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    checkCtl("lr.redir", C_REDIR, 32'h0000_0200, 1'b0);
    applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("lr.run", C_IDLE, 32'h0, 1'b0);
    checkStall("lr", 12, 12);

    // Jump wait never resolved: the 15th wait cycle aborts and the flag sticks.
    applyStimulus(1'b1, K_JUMP, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("to.pause", C_JUMP, 32'h0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b0, K_JUMP, 1'b0, 1'b0, 1'b0, 32'h0);
      checkCtl($sformatf("to.w%0d", i),
               (i < 15) ? C_JUMP : ((i == 15) ? C_ABORT : C_IDLE),
               32'h0, (i > 15));
    end
    checkStall("to", 27, 15);
    applyStimulus(1'b1, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("to.lpause", C_LDENT, 32'h0, 1'b1);
    applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b1, 32'h0);
    checkCtl("to.ldone", C_IDLE, 32'h0, 1'b1);
    applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("to.sticky", C_IDLE, 32'h0, 1'b1);
    checkStall("to.after", 28, 15);

    // Asynchronous reset pulse in the middle of a jump wait, between clock edges.
    applyStimulus(1'b1, K_JUMP, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("ar.pause", C_JUMP, 32'h0, 1'b1);
    applyStimulus(1'b0, K_JUMP, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("ar.wait", C_JUMP, 32'h0, 1'b1);
    #1 rst = 1'b1;
    #1;
    checkCtl("ar.inrst", C_IDLE, 32'h0, 1'b0);
    checkStall("ar.inrst", 0, 0);
    rst = 1'b0;
    applyStimulus(1'b0, K_JUMP, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCtl("ar.run", C_IDLE, 32'h0, 1'b0);
    checkStall("ar.run", 0, 0);

    // Twenty stall cycles from two ten-cycle load waits: the 4-bit counter pins at 15.
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b1, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int w = 0; w < 9; w++) begin
        applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
      end
      applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b1, 32'h0);
      checkCtl($sformatf("sat.done%0d", r), C_IDLE, 32'h0, 1'b0);
    end
    applyStimulus(1'b0, K_LOAD, 1'b0, 1'b0, 1'b0, 32'h0);
    checkStall("sat", 20, 15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum cycles spent in any wait state before timeout abort.
REQ-002 Parameter CNT_W, default 32: stall performance-counter width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port id_pause  input  1  decode pause request for the instruction currently in ID.
REQ-006 Port id_pause_kind  input  1  0 = JUMP (JAL/JALR), 1 = LOAD; valid only with id_pause.
REQ-007 Port ex_resolve  input  1  EX has resolved a control transfer this cycle.
REQ-008 Port ex_taken  input  1  resolved transfer redirects; valid only with ex_resolve.
REQ-009 Port ex_target  input  `XLEN_WIDTH  redirect address; valid with ex_resolve & ex_taken.
REQ-010 Port mem_load_done  input  1  load data returned this cycle.
REQ-011 Port pc_hold  output  1  PC keeps its value.
REQ-012 Port pc_load  output  1  PC loads pc_target next edge; overrides pc_hold.
REQ-013 Port pc_target  output  `XLEN_WIDTH  redirect address; 0 when pc_load=0.
REQ-014 Port if_id_hold / if_id_flush  output  1 each  freeze / bubble the IF->ID register.
REQ-015 Port id_ex_flush  output  1  bubble the ID->EX register.
REQ-016 Port timeout_err  output  1  sticky wait-timeout flag.
REQ-017 Port stall_cycles  output  CNT_W  count of cycles with pc_hold or pc_load asserted.

Function
REQ-018 FSM states SHALL be RUN, WAIT_JUMP, WAIT_LOAD; outputs are combinational from state and inputs, state registered.
REQ-019 Default every cycle: all control outputs 0, pc_target 0.
REQ-020 Any state, ex_resolve & ex_taken: pc_load=1, pc_target=ex_target, if_id_flush=1, id_ex_flush=1, next RUN; this SHALL beat id_pause and mem_load_done in the same cycle.
REQ-021 RUN, id_pause, kind JUMP, no redirect: pc_hold=1, if_id_flush=1, next WAIT_JUMP.
REQ-022 RUN, id_pause, kind LOAD, no redirect: pc_hold=1, if_id_hold=1, next WAIT_LOAD.
REQ-023 WAIT_JUMP without ex_resolve: pc_hold=1, if_id_flush=1, stay; ex_resolve & !ex_taken: all outputs 0, next RUN.
REQ-024 WAIT_LOAD without mem_load_done: pc_hold=1, if_id_hold=1, id_ex_flush=1, stay; mem_load_done: all outputs 0, next RUN (zero-cycle release).
REQ-025 Wait counter SHALL clear on entry to any wait state, increment each cycle in a wait state, and clear in RUN.
REQ-026 Counter reaching MAX_WAIT-1 in a wait state without release: pc_hold=0, if_id_flush=1, id_ex_flush=1, timeout_err set, next RUN.
REQ-027 timeout_err SHALL stay 1 until reset.
REQ-028 stall_cycles SHALL increment by 1 per qualifying cycle and saturate at all-ones.
REQ-029 ex_resolve & !ex_taken in RUN or WAIT_LOAD SHALL have no effect.

Reset
REQ-030 rst=1 SHALL immediately force state RUN, wait counter 0, timeout_err 0, stall_cycles 0, independent of clk.
REQ-031 Reset mid-wait SHALL abandon the wait; first cycle after release behaves as RUN with no pending hold.

Structure
REQ-032 State encodings, pause-kind codes and MAX_WAIT default SHALL live in a shared define header alongside the existing `XLEN_WIDTH / `true / `false constants.
REQ-033 Saturating counter SHALL be one sub-module, sat_counter (width parameter, inc, clr, value).

Verification
REQ-034 id_pause JUMP, ex_resolve & ex_taken 2 cycles later with ex_target=0x0000_0100 -> pc_hold 3 cycles, pc_load in cycle 3 with pc_target 0x100, state RUN, stall_cycles=3.
REQ-035 id_pause LOAD, mem_load_done 4 cycles later -> if_id_hold=1 and id_ex_flush=1 for 3 cycles, release in cycle 5, stall_cycles=4.
REQ-036 WAIT_LOAD, mem_load_done and ex_resolve & ex_taken same cycle (target 0x200) -> pc_load to 0x200, both flushes, state RUN.
REQ-037 id_pause JUMP, no ex_resolve for 20 cycles, MAX_WAIT=15 -> abort after 15 wait cycles, timeout_err=1 and held after later traffic.
REQ-038 rst pulsed asynchronously mid-WAIT_JUMP -> outputs 0 and stall_cycles 0 before next clk edge; CNT_W=4 with 20 stall cycles -> stall_cycles holds 15.
